// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: state encodings and key polarity shared by the debouncer and the pulse FSM
package key_debounce_pkg;
  typedef enum logic [1:0] {
    REL_STABLE = 2'b00,
    PRESS_WAIT = 2'b01,
    PRS_STABLE = 2'b10,
    REL_WAIT   = 2'b11
  } key_state_t;
  localparam logic KEY_ACTIVE = 1'b0;
endpackage

// File: rtl/key_debounce_sync_chain.sv
// sync_chain: STAGES-deep metastability synchronizer with a configurable reset value
module sync_chain #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clock or negedge reset)
    if (!reset) ff <= {STAGES{RST_VAL}};
    else        ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/key_debounce.sv
// key_debounce: synchronizes and debounces an active-low pushbutton into key_clean/busy
// KEY_EDGE_OUT_EN adds registered press_pulse/release_pulse outputs.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_raw,
  output logic key_clean,
  output logic busy
`ifdef KEY_EDGE_OUT_EN
  ,
  output logic press_pulse,
  output logic release_pulse
`endif
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic key_sync;
  logic done;
  logic [CW-1:0] cnt;
  key_state_t state, state_n;
  sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(~KEY_ACTIVE)) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (key_raw),
    .q    (key_sync)
  );
  // counter restarts on every state entry and only runs while timing a candidate
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= REL_STABLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state || !busy) ? '0 : cnt + 1'b1;
    end
  assign done = cnt == LAST;
  always_comb begin
    state_n = REL_STABLE;
    case (state)
      REL_STABLE: state_n = key_sync == KEY_ACTIVE ? PRESS_WAIT : REL_STABLE;
      PRESS_WAIT: state_n = key_sync != KEY_ACTIVE ? REL_STABLE : done ? PRS_STABLE : PRESS_WAIT;
      PRS_STABLE: state_n = key_sync != KEY_ACTIVE ? REL_WAIT : PRS_STABLE;
      REL_WAIT:   state_n = key_sync == KEY_ACTIVE ? PRS_STABLE : done ? REL_STABLE : REL_WAIT;
      default:    state_n = REL_STABLE;
    endcase
  end
  always_comb begin
    key_clean = state inside {PRS_STABLE, REL_WAIT} ? KEY_ACTIVE : ~KEY_ACTIVE;
    busy      = state inside {PRESS_WAIT, REL_WAIT};
  end
`ifdef KEY_EDGE_OUT_EN
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= state == PRESS_WAIT && state_n == PRS_STABLE;
      release_pulse <= state == REL_WAIT && state_n == REL_STABLE;
    end
`endif
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed checks of key_debounce with SYNC_STAGES=2, DEBOUNCE_CYCLES=4
module tb_key_debounce;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic key_raw = 1'b1;
  logic key_clean, busy;
  int n_vec = 0;
  int n_err = 0;
`ifdef KEY_EDGE_OUT_EN
  logic press_pulse, release_pulse;
`endif
  key_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .key_raw      (key_raw),
    .key_clean    (key_clean),
    .busy         (busy)
`ifdef KEY_EDGE_OUT_EN
    ,
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
`endif
  );
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic check(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %b want %b", tag, got, exp);
    end
  endtask
  task automatic outs(input logic ec, eb, ep, er, input string tag);
    check({tag, "/clean"}, key_clean, ec);
    check({tag, "/busy"}, busy, eb);
`ifdef KEY_EDGE_OUT_EN
    check({tag, "/press"}, press_pulse, ep);
    check({tag, "/release"}, release_pulse, er);
`endif
  endtask
  task automatic cyc(input logic raw, ec, eb, ep, er, input string tag);
    key_raw = raw;
    @(posedge clock);
    #1;
    outs(ec, eb, ep, er, tag);
  endtask
  // full accepted transition to level 'to': busy on edges 3..6, key_clean flips on edge 7
  task automatic settle(input logic to, input string tag);
    for (int i = 0; i < 8; i++)
      cyc(to, i >= 6 ? to : ~to, i >= 2 && i <= 5, i == 6 && !to, i == 6 && to,
          $sformatf("%s%0d", tag, i));
  endtask
  initial begin
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, $sformatf("rst%0d", i));
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, $sformatf("idle%0d", i));
    settle(1'b0, "press");
    settle(1'b1, "rel");
    for (int i = 0; i < 8; i++)
      cyc(i >= 3, 1'b1, i >= 2 && i <= 4, 1'b0, 1'b0, $sformatf("bounce%0d", i));
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, i == 2, 1'b0, 1'b0, $sformatf("pw%0d", i));
    #2 reset = 1'b0;
    #1 outs(1'b1, 1'b0, 1'b0, 1'b0, "rst_async");
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, $sformatf("rst_hold%0d", i));
    reset = 1'b1;
    settle(1'b0, "rstmid");
    settle(1'b1, "rel2");
    for (int i = 0; i < 11; i++)
      cyc(i inside {1, 3}, i < 10, i inside {2, 4, [6:9]}, i == 10, 1'b0, $sformatf("multi%0d", i));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "multi_end");
    for (int i = 0; i < 8; i++)
      cyc(i % 2 == 0, 1'b0, i >= 2 && i % 2 == 0, 1'b0, 1'b0, $sformatf("toggle%0d", i));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
